// File: rtl/id_eeprom_onewire_master.sv
// id_eeprom_onewire_master: Avalon-MM 1-Wire bus master for the board ID EEPROM.
// Reset/presence, single-bit and byte slots with fixed microsecond timing.
module id_eeprom_onewire_master #(
    parameter int CLK_DIV = 50
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    inout  wire         bidir_port
);

    localparam int PW = $clog2(CLK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        RST_LOW,
        RST_REL,
        SLOT_LOW,
        SLOT_REL
    } state_t;

    state_t        state;
    logic [PW-1:0] pre;
    logic [9:0]    us;
    logic [7:0]    tx;
    logic [7:0]    rx;
    logic [2:0]    bitcnt;
    logic          byte_mode;
    logic          bit_val;
    logic          drive_low;
    logic          presence;
    logic          last_bit;
    logic          irq_en;
    logic          done;
    logic          dq_s1;
    logic          dq_s2;
    logic          wr;
    logic          tick;
    logic          cur_bit;
    logic          busy;
    logic [9:0]    low_end;
    logic          unused_wd;

    assign wr         = chipselect & ~write_n;
    assign tick       = (pre == PRE_MAX);
    assign cur_bit    = byte_mode ? tx[bitcnt] : bit_val;
    assign low_end    = cur_bit ? 10'd5 : 10'd59;
    assign busy       = (state != IDLE);
    assign irq        = done & irq_en;
    assign bidir_port = drive_low ? 1'b0 : 1'bz;
    assign unused_wd  = ^writedata[31:8];

    // Two-flop synchronizer for the open-drain DQ line
    always_ff @(posedge clk) begin
        if (reset) begin
            dq_s1 <= 1'b1;
            dq_s2 <= 1'b1;
        end else begin
            dq_s1 <= bidir_port;
            dq_s2 <= dq_s1;
        end
    end

    // Registered read mux, updated every cycle from the presented address
    always_ff @(posedge clk) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            case (address)
                2'd0:    readdata <= {24'd0, rx};
                2'd1:    readdata <= {27'd0, done, irq_en, last_bit, presence, busy};
                2'd2:    readdata <= {31'd0, dq_s2};
                default: readdata <= '0;
            endcase
        end
    end

    // Transaction FSM with microsecond prescaler, slot timing and sampling
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pre       <= '0;
            us        <= '0;
            tx        <= '0;
            rx        <= '0;
            bitcnt    <= '0;
            byte_mode <= 1'b0;
            bit_val   <= 1'b0;
            drive_low <= 1'b0;
            presence  <= 1'b0;
            last_bit  <= 1'b0;
            irq_en    <= 1'b0;
            done      <= 1'b0;
        end else begin
            pre <= tick ? '0 : pre + 1'b1;
            if (tick) begin
                us <= us + 10'd1;
            end
            if (wr && address == 2'd1) begin
                irq_en <= writedata[3];
                if (writedata[4]) begin
                    done <= 1'b0;
                end
            end
            if ((state == SLOT_LOW || state == SLOT_REL) && tick && us == 10'd14) begin
                last_bit   <= dq_s2;
                rx[bitcnt] <= dq_s2;
            end
            case (state)
                IDLE: begin
                    if (wr && address == 2'd0) begin
                        tx        <= writedata[7:0];
                        byte_mode <= 1'b1;
                        bitcnt    <= '0;
                        drive_low <= 1'b1;
                        pre       <= '0;
                        us        <= '0;
                        done      <= 1'b0;
                        state     <= SLOT_LOW;
                    end else if (wr && address == 2'd1 && writedata[0]) begin
                        drive_low <= 1'b1;
                        pre       <= '0;
                        us        <= '0;
                        done      <= 1'b0;
                        state     <= RST_LOW;
                    end else if (wr && address == 2'd1 && writedata[1]) begin
                        bit_val   <= writedata[2];
                        byte_mode <= 1'b0;
                        bitcnt    <= '0;
                        drive_low <= 1'b1;
                        pre       <= '0;
                        us        <= '0;
                        done      <= 1'b0;
                        state     <= SLOT_LOW;
                    end
                end
                RST_LOW: begin
                    if (tick && us == 10'd479) begin
                        drive_low <= 1'b0;
                        state     <= RST_REL;
                    end
                end
                RST_REL: begin
                    if (tick && us == 10'd549) begin
                        presence <= ~dq_s2;
                    end
                    if (tick && us == 10'd959) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                SLOT_LOW: begin
                    if (tick && us == low_end) begin
                        drive_low <= 1'b0;
                        state     <= SLOT_REL;
                    end
                end
                SLOT_REL: begin
                    if (tick && us == 10'd69) begin
                        if (byte_mode && bitcnt != 3'd7) begin
                            bitcnt    <= bitcnt + 3'd1;
                            drive_low <= 1'b1;
                            us        <= '0;
                            state     <= SLOT_LOW;
                        end else begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    drive_low <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/id_eeprom_onewire_master.md
# id_eeprom_onewire_master

Hardware 1-Wire bus master for the board ID EEPROM. It replaces software bit-banging of the ID EEPROM data PIO with an Avalon-MM slave on the Nios II data master and an open-drain `bidir_port` to the EEPROM DQ pin. It generates reset/presence, single-bit and byte slots with fixed microsecond timing derived from `clk`, and raises an optional completion interrupt.

## Interface

- `CLK_DIV`, 50: `clk` cycles per 1 µs tick (50 MHz system clock). Legal range is 2 or more.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `address`  in  2  register select.
- `chipselect`  in  1  slave select.
- `write_n`  in  1  active-low write strobe.
- `writedata`  in  32  write data.
- `readdata`  out  32  registered read data. Unused bits read 0.
- `irq`  out  1  level interrupt. Equals `done & irq_en`.
- `bidir_port`  inout  1  1-Wire DQ. Driven `1'b0` or `1'bZ` only, never driven high.

## Operation

Register map:
- **addr 0, DATA**
  - Write while idle: loads `tx[7:0]` and starts an 8-slot byte transaction, LSB first.
  - Read: `rx[7:0]`, the bits sampled during the last byte transaction.
  - To read a byte, write 0xFF.
- **addr 1, CTRL/STATUS**
  - Write bit0=1: start reset/presence. Only acted on when idle.
  - Write bit1=1: start a single-bit slot with value bit2. Only acted on when idle.
  - Write bit3: sets `irq_en`. Always accepted.
  - Write bit4=1: clears `done`. Always accepted.
  - Read: bit0 `busy`, bit1 `presence`, bit2 `last_bit`, bit3 `irq_en`, bit4 `done`.
- **addr 2:** read bit0 is the synchronized DQ level.
- **addr 3:** reads 0; writes ignored.

Command rules:
- bit0 and bit1 set in the same write: reset wins, the bit slot is dropped.
- Start writes while `busy=1` are ignored entirely. `irq_en` and `done`-clear still apply.
- A start clears `done`.
- DQ input passes through a 2-flop synchronizer. All samples use the synchronized value.

FSM states: IDLE, RST_LOW, RST_REL, SLOT_LOW, SLOT_REL.
- **IDLE -> RST_LOW** on reset command. DQ driven low for 480 µs.
- **RST_LOW -> RST_REL.** DQ released.
  - `presence` = !DQ sampled at 70 µs after release.
  - Exit to IDLE at 480 µs after release (960 µs total).
- **IDLE -> SLOT_LOW** on a bit or byte command.
  - Drive low for 6 µs when the bit is 1.
  - Drive low for 60 µs when the bit is 0.
- **SLOT_LOW -> SLOT_REL.**
  - Sample DQ at 15 µs from slot start into `last_bit` and `rx[bitcnt]`.
  - A written 0 samples 0 by construction.
  - Slot ends at 70 µs from slot start, which includes recovery time.
- **After SLOT_REL:**
  - Byte mode with `bitcnt < 7`: increment `bitcnt`, go to SLOT_LOW.
  - Otherwise: go to IDLE.
- **Entering IDLE from any transaction:** set `done`.

## Timing

Reset values:
- `readdata=0`, `irq=0`, `bidir_port=Z`.
- `busy=0`, `presence=0`, `last_bit=0`, `irq_en=0`, `done=0`, `rx=0`.
- State is IDLE.

Tick and phase timing:
- The prescaler restarts at 0 on command acceptance.
- A 1 µs tick fires every `CLK_DIV` cycles.
- Phase lengths are exact: RST_LOW is `480*CLK_DIV` cycles, and a bit slot is `70*CLK_DIV` cycles.

Cycle-level behaviour:
- On the cycle after the accepting write edge: `busy=1` and DQ driven low.
- Byte slots follow each other with no gap. A byte takes `560*CLK_DIV` cycles.
- `done` and `irq` rise on the same edge where `busy` falls.
- `readdata` is registered: valid 1 cycle after the address is presented, every cycle, with no read strobe.

Boundary cases:
- Slave holding DQ low at the start: the master still runs the full timing. `presence` then reflects the sample.
- `reset` asserted mid-transaction: on the next edge, DQ goes to Z, state goes to IDLE, and all registers take their reset values.
- A `done`-clear write on the same edge that `done` is set: the set wins.

## Test plan

- **Reset/presence with slave.** Slave model pulls DQ low 30–270 µs after release. -> Low pulse of exactly 24000 clocks; `presence=1`, `done=1`, `busy=0` at 48000 clocks.
- **Reset/presence, no slave.** Same command with no slave. -> `presence=0`, DQ released at clock 24000.
- **Byte write.** Write DATA=0xA5. -> Eight low pulses of 6/60/6/60/60/6/60/6 µs (LSB first 1,0,1,0,0,1,0,1), each slot 3500 clocks; `irq=1` when `irq_en=1`.
- **Byte read.** Write DATA=0xFF with slave returning 0x3C (slave holds DQ low to 30 µs on 0 bits). -> DATA reads 0x3C; `last_bit=0`.
- **Busy ignore and command priority.** Write DATA=0x00 while busy. -> Ignored; `tx` unchanged, waveform unchanged. CTRL write 0x03 when idle. -> Reset pulse only.
- **Reset mid-operation.** Assert `reset` mid-byte. -> Next edge: DQ=Z, `busy=0`, `rx=0`, `readdata=0` the following cycle.
